// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one I-cache request in flight and
// buffers returned {pc, inst} pairs for decode. Optional perf counters: IFETCH_PERF_EN.
`timescale 1ns/1ps

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        inst_rreq,
  output logic [31:0] inst_addr,
  input  logic        inst_valid,
  input  logic [31:0] inst_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_miss_cyc
`endif
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [31:0]        next_pc_q, next_pc_d;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]        pc_mem   [IBUF_DEPTH];
  logic [31:0]        inst_mem [IBUF_DEPTH];

  logic               push, pop, flush;
  logic [31:0]        redir_tgt;
  logic [CNT_W-1:0]   post_cnt;

  assign inst_addr = req_pc_q;
  assign id_valid  = (count_q != '0);
  assign id_pc     = pc_mem[rd_ptr_q];
  assign id_inst   = inst_mem[rd_ptr_q];
  assign pop       = id_valid & id_ready;
  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign post_cnt  = count_q + CNT_W'(1) - CNT_W'(pop);

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    next_pc_d = next_pc_q;
    push      = 1'b0;
    flush     = 1'b0;
    inst_rreq = 1'b0;

    // A redirect always retargets the fetch stream and empties the buffer.
    if (redirect_valid) begin
      flush     = 1'b1;
      next_pc_d = redir_tgt;
    end

    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && (count_q < DEPTH_C)) begin
          state_d  = S_REQ;
          req_pc_d = next_pc_q;
        end
      end
      S_REQ: begin
        inst_rreq = 1'b1;
        state_d   = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          if (inst_valid) begin
            state_d  = S_REQ;
            req_pc_d = redir_tgt;
          end else begin
            state_d = S_DROP;
          end
        end else if (inst_valid) begin
          push      = 1'b1;
          next_pc_d = req_pc_q + 32'd4;
          if (post_cnt < DEPTH_C) begin
            state_d  = S_REQ;
            req_pc_d = req_pc_q + 32'd4;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        // The stale request is still live in the cache; hold inst_addr until it returns.
        if (inst_valid) begin
          state_d  = S_REQ;
          req_pc_d = next_pc_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q   <= S_IDLE;
      req_pc_q  <= RESET_PC;
      next_pc_q <= RESET_PC;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      next_pc_q <= next_pc_d;
      if (flush) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; count_q alone says which entries are live.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= req_pc_q;
      inst_mem[wr_ptr_q] <= inst_out;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      perf_fetch_cnt <= '0;
      perf_miss_cyc  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(push);
      perf_miss_cyc  <= perf_miss_cyc +
                        32'(((state_q == S_WAIT) || (state_q == S_DROP)) && !inst_valid);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a cycle-stepped I-cache model; a configurable
// address misses with a fixed extra latency, everything else hits next cycle.
`timescale 1ns/1ps

module tb_inst_fetch_unit;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        inst_rreq;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_miss_cyc;
`endif

  int checks   = 0;
  int failures = 0;

  // cache model state
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [31:0] miss_addr;
  int          miss_lat;

  inst_fetch_unit #(.RESET_PC(32'h0), .IBUF_DEPTH(4)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .inst_rreq      (inst_rreq),
    .inst_addr      (inst_addr),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_ready       (id_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_miss_cyc  (perf_miss_cyc)
`endif
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_1357;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle, then play the cache for the new cycle.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
    inst_valid = 1'b0;
    inst_out   = 32'h0;
    if (cpu_rst) begin
      pend = 1'b0;
    end else if (inst_rreq) begin
      pend      = 1'b1;
      pend_addr = inst_addr;
      pend_cnt  = (inst_addr == miss_addr) ? miss_lat : 0;
    end else if (pend) begin
      if (pend_cnt == 0) begin
        inst_valid = 1'b1;
        inst_out   = word_of(pend_addr);
        pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  // Leaves the bench in the first post-reset cycle (DUT in IDLE).
  task automatic do_reset();
    cpu_rst        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    cpu_rst = 1'b0;
  endtask

  task automatic redirect_now(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (inst_rreq && inst_addr == a) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  initial begin
    bit          ok;
    bit          hold_ok;
    int          n;
    int          pops;
    int          reqs;
    logic [31:0] last_req;

    inst_valid = 1'b0;
    inst_out   = 32'h0;
    id_ready   = 1'b1;
    miss_addr  = 32'h1;
    miss_lat   = 0;
    pend       = 1'b0;

    // Reset state and streaming at one instruction per two cycles
    cpu_rst        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    check("rst_rreq", 32'(inst_rreq), 32'd0);
    check("rst_addr", inst_addr, 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    cpu_rst = 1'b0;
    check("c0_rreq", 32'(inst_rreq), 32'd0);
    pops = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (inst_rreq !== ((k % 2) == 1)) hold_ok = 1'b0;
      if (inst_addr !== 32'((k - 1) / 2) * 32'd4) hold_ok = 1'b0;
      if (id_valid) begin
        check("stream_pc", id_pc, 32'(pops) * 32'd4);
        check("stream_inst", id_inst, word_of(32'(pops) * 32'd4));
        pops++;
      end
    end
    check("stream_rreq_addr_pattern", 32'(hold_ok), 32'd1);
    check("stream_pops", 32'(pops), 32'd4);

    // Fill the buffer with decode stalled, then release a single slot
    id_ready = 1'b0;
    do_reset();
    reqs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (inst_rreq) reqs++;
    end
    check("full_reqs", 32'(reqs), 32'd4);
    check("full_rreq_idle", 32'(inst_rreq), 32'd0);
    check("full_id_valid", 32'(id_valid), 32'd1);
    check("full_head_pc", id_pc, 32'h0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    reqs = 0;
    last_req = 32'hDEAD_BEEF;
    for (int k = 0; k < 10; k++) begin
      if (inst_rreq) begin
        reqs++;
        last_req = inst_addr;
      end
      tick();
    end
    check("refill_reqs", 32'(reqs), 32'd1);
    check("refill_addr", last_req, 32'h10);
    check("refill_head_pc", id_pc, 32'h4);

    // 20-cycle miss at 0x40
    id_ready  = 1'b1;
    miss_addr = 32'h40;
    miss_lat  = 20;
    do_reset();
    redirect_now(32'h40);
    wait_req_addr(32'h40, 10, ok);
    check("miss_req_seen", 32'(ok), 32'd1);
    hold_ok = 1'b1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (inst_rreq || inst_addr !== 32'h40) hold_ok = 1'b0;
      if (inst_valid) break;
      n++;
    end
    check("miss_wait_cycles", 32'(n), 32'd20);
    check("miss_addr_hold", 32'(hold_ok), 32'd1);
    tick();
    check("miss_id_valid", 32'(id_valid), 32'd1);
    check("miss_id_pc", id_pc, 32'h40);
    check("miss_id_inst", id_inst, word_of(32'h40));
`ifdef IFETCH_PERF_EN
    check("perf_miss_cyc", perf_miss_cyc, 32'd20);
    check("perf_fetch_cnt", perf_fetch_cnt, 32'd1);
`endif

    // Redirect to 0x100 while a miss at 0x80 is outstanding
    id_ready  = 1'b0;
    miss_addr = 32'h80;
    miss_lat  = 10;
    do_reset();
    redirect_now(32'h78);
    wait_req_addr(32'h80, 20, ok);
    check("redir_req80_seen", 32'(ok), 32'd1);
    tick();
    tick();
    check("redir_pre_id_valid", 32'(id_valid), 32'd1);
    check("redir_pre_head", id_pc, 32'h78);
    redirect_now(32'h100);
    check("redir_flush", 32'(id_valid), 32'd0);
    hold_ok = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (inst_rreq || inst_addr !== 32'h80) hold_ok = 1'b0;
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("drop_return_seen", 32'(ok), 32'd1);
    check("drop_addr_hold", 32'(hold_ok), 32'd1);
    tick();
    check("drop_next_rreq", 32'(inst_rreq), 32'd1);
    check("drop_next_addr", inst_addr, 32'h100);
    check("drop_discarded", 32'(id_valid), 32'd0);
    id_ready = 1'b1;
    tick();
    tick();
    check("redir_first_valid", 32'(id_valid), 32'd1);
    check("redir_first_pc", id_pc, 32'h100);

    // Unaligned redirect coinciding with a cache return
    miss_addr = 32'h1;
    do_reset();
    tick();
    tick();
    check("same_cyc_ret", 32'(inst_valid), 32'd1);
    redirect_now(32'h203);
    check("same_cyc_rreq", 32'(inst_rreq), 32'd1);
    check("same_cyc_addr", inst_addr, 32'h200);
    check("same_cyc_discard", 32'(id_valid), 32'd0);
    tick();
    tick();
    check("same_cyc_pc", id_pc, 32'h200);

    // PC wrap at the top of the address space
    do_reset();
    redirect_now(32'hFFFF_FFFC);
    wait_req_addr(32'hFFFF_FFFC, 10, ok);
    check("wrap_req_seen", 32'(ok), 32'd1);
    tick();
    tick();
    check("wrap_rreq", 32'(inst_rreq), 32'd1);
    check("wrap_addr", inst_addr, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

    // Reset in the middle of a miss
    miss_addr = 32'h0;
    miss_lat  = 15;
    do_reset();
    tick();
    tick();
    tick();
    cpu_rst = 1'b1;
    tick();
    check("rst_mid_rreq", 32'(inst_rreq), 32'd0);
    check("rst_mid_addr", inst_addr, 32'h0);
    check("rst_mid_id_valid", 32'(id_valid), 32'd0);
    cpu_rst = 1'b0;
    tick();
    check("rst_mid_restart", 32'(inst_rreq), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the 2-way instruction cache. It owns the fetch PC, issues one request at a time on the cache's CPU-side interface (inst_rreq/inst_addr, answered by inst_valid/inst_out), and buffers returned instructions with their PCs in a small FIFO. The decode stage drains that FIFO through a valid/ready handshake. Branch redirects flush the FIFO and discard any fetch already in flight.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC after reset
IBUF_DEPTH, 4, instruction FIFO entries (power of 2, >=2)

Ports:
cpu_clk  input  1  clock
cpu_rst  input  1  reset; synchronous, active-high
inst_rreq  output  1  fetch request to I-cache; one-cycle pulse per request
inst_addr  output  32  fetch address; held stable from the inst_rreq cycle through the inst_valid cycle inclusive
inst_valid  input  1  I-cache hit/return pulse; one cycle
inst_out  input  32  instruction; valid only while inst_valid=1
redirect_valid  input  1  branch/exception redirect
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0)
id_valid  output  1  FIFO head valid to decode
id_pc  output  32  PC of head entry
id_inst  output  32  instruction of head entry
id_ready  input  1  decode accepts the head this cycle

Behaviour:
- Reset (cpu_rst=1 at an edge): state=IDLE, fetch_pc=RESET_PC, FIFO count=0, rd/wr ptr=0. Outputs: inst_rreq=0, inst_addr=RESET_PC, id_valid=0. id_pc/id_inst are don't-care while id_valid=0. Any inst_valid seen in IDLE is ignored.
- Registers:
  - req_pc: drives inst_addr; frozen while a request is outstanding.
  - next_pc: next address to fetch.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE: no request outstanding. Redirect -> next_pc=redirect_pc, stay in IDLE. Else if count<IBUF_DEPTH -> REQ, with req_pc=next_pc.
  - REQ: inst_rreq=1 for exactly this cycle. Next state is WAIT, or DROP if redirect_valid=1 this cycle (next_pc=redirect_pc).
  - WAIT: hold inst_addr. If inst_valid and no redirect: push {req_pc, inst_out}, next_pc=req_pc+4. Then go to REQ (req_pc=req_pc+4) if post-push/post-pop count<IBUF_DEPTH, else IDLE. If redirect (with or without inst_valid): discard any return, set next_pc=redirect_pc, flush FIFO, then go to REQ if inst_valid else DROP.
  - DROP: hold inst_addr (old request is still live in the cache) and wait for inst_valid. Discard the returned data, then go to REQ with req_pc=next_pc. A further redirect in DROP overwrites next_pc (latest wins), including in the inst_valid cycle.
- Best throughput: one instruction per 2 cycles on cache hits (REQ, WAIT/hit, REQ, ...). Misses stretch WAIT with no limit.
- FIFO:
  - id_valid = (count!=0); id_pc/id_inst come from the head, combinationally.
  - Pop on id_valid & id_ready. Push and pop in the same cycle are allowed, including when full.
  - Pointers wrap modulo IBUF_DEPTH.
  - Redirect flush: count=0 at the next edge and id_valid=0 the following cycle. A pop in the redirect cycle is still honoured (decode took the entry).
- PC arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. inst_addr[1:0] is always 0.
- At most one request outstanding at any time. inst_rreq is never asserted outside REQ.
- Reset mid-miss: FSM returns to IDLE. The cache is reset by the same source, so no stale inst_valid is accepted.

Optional Feature:
IFETCH_PERF_EN defined:
- Adds outputs perf_fetch_cnt[31:0] (instructions pushed into the FIFO) and perf_miss_cyc[31:0] (cycles spent in WAIT or DROP with inst_valid=0).
- Both counters reset to 0, wrap silently, and are unaffected by redirect.
Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, cache always hits, id_ready=1 -> inst_rreq pulses every 2nd cycle starting cycle 1; id_pc sequence 0x0,0x4,0x8,0xC; inst_addr stable across each REQ/WAIT pair.
- id_ready=0, IBUF_DEPTH=4, all hits -> exactly 4 pushes then FSM parks in IDLE with inst_rreq=0; raising id_ready for one cycle -> exactly one new request issued.
- Miss: inst_valid delayed 20 cycles -> inst_rreq high once, inst_addr held at 0x40 for all 21 cycles; entry {0x40, inst_out} appears on id_* afterwards.
- redirect_valid with redirect_pc=0x100 during the WAIT of a miss at 0x80 -> FIFO empty the next cycle; inst_addr stays 0x80 until inst_valid; that return is dropped; next request addr=0x100 and the first id_pc is 0x100.
- Redirect to 0x203 in the same cycle as inst_valid -> return discarded, next inst_addr=0x200, no DROP state entered.
- Fetch at 0xFFFF_FFFC hits -> next inst_addr=0x0000_0000. With IFETCH_PERF_EN defined, the miss scenario above gives perf_miss_cyc=20 and perf_fetch_cnt=1.
